// File: rtl/slave_port_pkg.sv
// Shared definitions for the slave-side serial port blocks: FSM encoding and default sizes.
package slave_port_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/slave_out_port_pkt_if.sv
// Bus bundle between the slave core / master return path and the serial output port.
interface slave_out_port_pkt_if
  import slave_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) ();

  logic [DATA_WIDTH-1:0]         data_in;
  logic                          slave_valid;
  logic                          slave_ready;
  logic                          master_ready;
  logic                          tx_data;
  logic                          tx_busy;
  logic                          tx_done;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  // Port view: takes words and master flow control, drives the serial line and status.
  modport slave (
    input  data_in, slave_valid, master_ready,
    output slave_ready, tx_data, tx_busy, tx_done, fifo_count
  );

  // Environment view: slave core plus master receiver.
  modport master (
    output data_in, slave_valid, master_ready,
    input  slave_ready, tx_data, tx_busy, tx_done, fifo_count
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is presented on dout without a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop never frees a slot early.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/slave_out_port_pkt.sv
// Buffered slave output port: queues parallel words and serialises them onto a 1-bit line,
// with optional start bit, selectable bit order and master back-pressure.
module slave_out_port_pkt
  import slave_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          START_BIT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  slave_out_port_pkt_if.slave   bus
);

  localparam int unsigned BCW = $clog2(DATA_WIDTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_adv;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  tx_data_q, tx_data_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  tx_done_q, tx_done_d;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.slave_valid),
    .pop   (pop),
    .din   (bus.data_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.slave_ready = !fifo_full;
  assign bus.fifo_count  = fifo_count;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_busy     = tx_busy_q;
  assign bus.tx_done     = tx_done_q;

  // The bit on the wire is always the leading end of the shift register.
  function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  assign shift_adv = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[DATA_WIDTH-1:1]};

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_data_d = tx_data_q;
    tx_busy_d = tx_busy_q;
    tx_done_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_data_d = 1'b0;
        tx_busy_d = 1'b0;
        if (!fifo_empty && bus.master_ready) begin
          pop       = 1'b1;
          shift_d   = fifo_dout;
          bit_cnt_d = '0;
          tx_busy_d = 1'b1;
          if (START_BIT) begin
            state_d   = START;
            tx_data_d = 1'b1;
          end else begin
            state_d   = DATA;
            tx_data_d = lead_bit(fifo_dout);
          end
        end
      end
      START: begin
        if (bus.master_ready) begin
          state_d   = DATA;
          tx_data_d = lead_bit(shift_q);
        end
      end
      DATA: begin
        if (bus.master_ready) begin
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            state_d   = DONE;
            tx_data_d = 1'b0;
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            shift_d   = shift_adv;
            tx_data_d = lead_bit(shift_adv);
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        tx_data_d = 1'b0;
        tx_busy_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        tx_data_d = 1'b0;
        tx_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_data_q <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_data_q <= tx_data_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

// File: doc/slave_out_port_pkt.md
Name: slave_out_port_pkt

Overview:
Parametrised successor of the single-word slave output port. Buffers up to FIFO_DEPTH parallel words from the slave side in an internal FIFO and serialises each onto the 1-bit bus line toward the master. Frames are optionally start-bit delimited and sent LSB- or MSB-first. The master can stall mid-frame with master_ready. Sits between a slave core and the system bus serial return path.

Parameters:
DATA_WIDTH, 8, bits per word (2..32)
FIFO_DEPTH, 4, buffered words; power of two, >=2
MSB_FIRST, 0, 1 = send bit DATA_WIDTH-1 first; 0 = send bit 0 first
START_BIT, 1, 1 = emit a single '1' start bit before the data bits; 0 = no framing bit

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
data_in  in  DATA_WIDTH  parallel word from slave core
slave_valid  in  1  data_in valid
slave_ready  out  1  FIFO not full; a word is pushed when slave_valid && slave_ready at a rising edge
master_ready  in  1  master accepts bits; low = stall
tx_data  out  1  registered serial data line; idles 0
tx_busy  out  1  high while a frame is in progress (START or DATA)
tx_done  out  1  one-cycle pulse after the last data bit of a frame
fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Interface decision: one clock, clk. Reset port reset is asynchronous and active-high.
- Reset values: tx_data=0, tx_busy=0, tx_done=0, fifo_count=0, slave_ready=1. The FSM enters IDLE and the FIFO pointers clear.
- slave_ready = (fifo_count != FIFO_DEPTH), from registered count only.
  - A pop in the same cycle does not raise slave_ready. There is no push when full.
- Push and pop in the same cycle: count unchanged, both operations take effect.
- No bypass: a word pushed at edge N is poppable at edge N+1 at the earliest.
- FSM states: IDLE, START, DATA, DONE.
- IDLE: tx_data=0.
  - If fifo_count!=0 && master_ready: pop head into the shift register and clear the bit counter.
  - Then go to START if START_BIT=1, else go to DATA with the first data bit driven.
- START: tx_data=1 for one cycle. Advance to DATA only when master_ready=1 at the edge; otherwise hold.
- DATA: tx_data is the current bit (index 0 upward if MSB_FIRST=0, downward from DATA_WIDTH-1 otherwise).
  - The counter advances only when master_ready=1.
  - With master_ready=0, the bit and counter hold; tx_data is unchanged.
  - After bit DATA_WIDTH-1 is accepted, go to DONE.
- DONE: tx_done=1 and tx_data=0 for exactly one cycle, then IDLE unconditionally.
- Minimum inter-frame gap is 2 cycles (DONE + IDLE).
- tx_busy=1 in START and DATA only.
- Latency, START_BIT=1, master_ready held high, push at edge N into an empty FIFO:
  - start bit visible after edge N+1.
  - data bits after edges N+2..N+1+DATA_WIDTH.
  - tx_done after edge N+2+DATA_WIDTH.
- FIFO order is strict first-in first-out. Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- master_ready low in IDLE: no pop. Words keep accumulating until full.
- Reset mid-frame: the frame is aborted immediately and the buffered words are discarded. tx_done is not pulsed.
- slave_valid while full: word dropped, no state change. The slave must hold slave_valid until it sees slave_ready.

Decomposition:
- Shared package slave_port_pkg:
  - FSM state encoding constants (IDLE=2'd0, START=2'd1, DATA=2'd2, DONE=2'd3).
  - Common DATA_WIDTH default.
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - Ports: push, pop, din, dout, count, full, empty.
  - Also reused by the planned master-side input port.
- Top level: FSM plus shift register and bit counter.

Test Plan:
- Reset pulse for 3 cycles, then idle -> tx_data=0, tx_busy=0, slave_ready=1, fifo_count=0.
- Push 8'hAA with master_ready=1, default params -> after edge N+1 tx_data=1 (start bit); bits 0,1,0,1,0,1,0,1; tx_done pulses once at edge N+10.
- master_ready=0 while pushing 5 words (FIFO_DEPTH=4) -> slave_ready drops after the 4th push; 5th word not accepted; fifo_count=4. Raise master_ready -> 4 frames emitted in order.
- Drop master_ready for 3 cycles at data bit 3 of 8'hC3 -> tx_data holds bit 3 (=0) for 3 extra cycles; frame completes with correct bits; tx_done delayed by 3 cycles.
- MSB_FIRST=1, START_BIT=0 instance, push 8'h81 -> tx_data 1,0,0,0,0,0,0,1 starting at edge N+1; tx_done at edge N+9.
- Assert reset during data bit 4 with 2 words queued -> tx_data=0 immediately; fifo_count=0; no tx_done; next pushed word transmits normally.
